// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_match.sv
// Source/producer comparator: a match needs a live read, a live write and rd != x0.
module hazard_match (
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] rd,
  input  logic       regwrite,
  output logic       match
);

  assign match = use_src && regwrite && (rd != 5'd0) && (rd == src);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage RV32 hazard controller: stall/flush/freeze/forward plus perf counters.
// Define HAZARD_FORWARD_EN to enable EX operand forwarding from MEM and WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             is_branch_id,
  input  logic             redirect_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic [4:0]       rd_mem,
  input  logic             regwrite_mem,
  input  logic             memread_mem,
  input  logic [4:0]       rd_wb,
  input  logic             regwrite_wb,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             pcsel_gate,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic rs1_ex_hit, rs1_mem_hit, rs1_wb_hit;
  logic rs2_ex_hit, rs2_mem_hit, rs2_wb_hit;
  logic branch_hit, data_stall;
  hz_state_e cls, state_q;

  hazard_match u_rs1_ex  (.src(rs1_id), .use_src(use_rs1_id), .rd(rd_ex),  .regwrite(regwrite_ex),  .match(rs1_ex_hit));
  hazard_match u_rs1_mem (.src(rs1_id), .use_src(use_rs1_id), .rd(rd_mem), .regwrite(regwrite_mem), .match(rs1_mem_hit));
  hazard_match u_rs1_wb  (.src(rs1_id), .use_src(use_rs1_id), .rd(rd_wb),  .regwrite(regwrite_wb),  .match(rs1_wb_hit));
  hazard_match u_rs2_ex  (.src(rs2_id), .use_src(use_rs2_id), .rd(rd_ex),  .regwrite(regwrite_ex),  .match(rs2_ex_hit));
  hazard_match u_rs2_mem (.src(rs2_id), .use_src(use_rs2_id), .rd(rd_mem), .regwrite(regwrite_mem), .match(rs2_mem_hit));
  hazard_match u_rs2_wb  (.src(rs2_id), .use_src(use_rs2_id), .rd(rd_wb),  .regwrite(regwrite_wb),  .match(rs2_wb_hit));

  // Branches compare in ID, so their operands must already be in the register file.
  assign branch_hit = is_branch_id &&
                      (rs1_ex_hit || rs1_mem_hit || rs1_wb_hit ||
                       rs2_ex_hit || rs2_mem_hit || rs2_wb_hit);

`ifdef HAZARD_FORWARD_EN
  logic load_use;
  logic a_mem_hit, a_wb_hit, b_mem_hit, b_wb_hit;
  logic unused_fwd;

  hazard_match u_a_mem (.src(rs1_ex), .use_src(1'b1), .rd(rd_mem), .regwrite(regwrite_mem), .match(a_mem_hit));
  hazard_match u_a_wb  (.src(rs1_ex), .use_src(1'b1), .rd(rd_wb),  .regwrite(regwrite_wb),  .match(a_wb_hit));
  hazard_match u_b_mem (.src(rs2_ex), .use_src(1'b1), .rd(rd_mem), .regwrite(regwrite_mem), .match(b_mem_hit));
  hazard_match u_b_wb  (.src(rs2_ex), .use_src(1'b1), .rd(rd_wb),  .regwrite(regwrite_wb),  .match(b_wb_hit));

  assign load_use   = !is_branch_id && memread_ex && (rs1_ex_hit || rs2_ex_hit);
  assign data_stall = branch_hit || load_use;

  // The younger MEM result wins over WB when both write the same register.
  assign fwd_a = a_mem_hit ? FWD_MEM : (a_wb_hit ? FWD_WB : FWD_REG);
  assign fwd_b = b_mem_hit ? FWD_MEM : (b_wb_hit ? FWD_WB : FWD_REG);

  assign unused_fwd = memread_mem;
`else
  logic any_hit;
  logic unused_fwd;

  // Without forwarding a consumer waits until its producer has written back.
  assign any_hit    = rs1_ex_hit || rs1_mem_hit || rs1_wb_hit ||
                      rs2_ex_hit || rs2_mem_hit || rs2_wb_hit;
  assign data_stall = branch_hit || (!is_branch_id && any_hit);

  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;

  assign unused_fwd = &{1'b0, rs1_ex, rs2_ex, memread_ex, memread_mem};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls = ST_RUN;
    if (dmem_busy)        cls = ST_FREEZE;
    else if (data_stall)  cls = ST_STALL;
    else if (redirect_id) cls = ST_FLUSH;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    pcsel_gate   = 1'b1;
    unique case (cls)
      ST_FREEZE: begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        ex_mem_en  = 1'b0;
        mem_wb_en  = 1'b0;
        pcsel_gate = 1'b0;
      end
      ST_STALL: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        pcsel_gate   = 1'b0;
      end
      ST_FLUSH: if_id_flush = 1'b1;
      default: ;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      state_q   <= cls;
      cycle_cnt <= sat_inc(cycle_cnt);
      if (cls == ST_STALL)  stall_cnt  <= sat_inc(stall_cnt);
      if (cls == ST_FLUSH)  flush_cnt  <= sat_inc(flush_cnt);
      if (cls == ST_FREEZE) freeze_cnt <= sat_inc(freeze_cnt);
    end
  end

  assign state_o = state_q;

endmodule
